fifo_control: RTL and testbench

Pointer and flag controller for the FIFO storage array (`memoria`). It accepts push/pop requests from the neighbouring stages and drives the array's `wr_enable`, `rd_enable`, `wr_ptr` and `rd_ptr`. It tracks occupancy and produces full/empty, almost-full/almost-empty and error flags. It also produces a read-valid strobe aligned with the array's registered `FIFO_data_out`.

---
 rtl/fifo_control_if.sv | 30 +++
 rtl/fifo_control.sv | 74 +++++++
 tb/tb_fifo_control.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_control_if.sv
// rtl/fifo_control_if.sv - push/pop handshake and status bundle for fifo_control
interface fifo_control_if #(
    parameter int address_width = 2
);
    logic                     push;
    logic                     pop;
    logic                     wr_enable;
    logic                     rd_enable;
    logic [address_width-1:0] wr_ptr;
    logic [address_width-1:0] rd_ptr;
    logic [address_width:0]   count;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic                     fifo_error;
    logic                     valid_out;

    modport master (
        output push, pop,
        input  wr_enable, rd_enable, wr_ptr, rd_ptr, count,
        input  full, empty, almost_full, almost_empty, fifo_error, valid_out
    );

    modport slave (
        input  push, pop,
        output wr_enable, rd_enable, wr_ptr, rd_ptr, count,
        output full, empty, almost_full, almost_empty, fifo_error, valid_out
    );
endinterface

// File: rtl/fifo_control.sv
// rtl/fifo_control.sv - FIFO pointer/occupancy/flag controller; FIFO_ERR_STICKY_EN latches fifo_error until reset
module fifo_control #(
    parameter int address_width    = 2,
    parameter int almost_full_thr  = 3,
    parameter int almost_empty_thr = 1
) (
    input  logic          clk,
    input  logic          reset,
    fifo_control_if.slave bus
);
    localparam int depth = 1 << address_width;
    localparam logic [address_width:0] depth_c  = depth[address_width:0];
    localparam logic [address_width:0] af_thr_c = almost_full_thr[address_width:0];
    localparam logic [address_width:0] ae_thr_c = almost_empty_thr[address_width:0];

    logic [address_width-1:0] wr_ptr_q;
    logic [address_width-1:0] rd_ptr_q;
    logic [address_width:0]   count_q;
    logic                     valid_q;
    logic                     error_q;
    logic                     full;
    logic                     empty;
    logic                     pop_acc;
    logic                     push_acc;
    logic                     error_now;

    assign full  = (count_q == depth_c);
    assign empty = (count_q == '0);

    // Strobes are gated by reset so the array sees no access while reset is held low.
    assign pop_acc   = reset && bus.pop && !empty;
    assign push_acc  = reset && bus.push && (!full || pop_acc);
    assign error_now = (bus.push && !push_acc) || (bus.pop && empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            valid_q <= pop_acc;
`ifdef FIFO_ERR_STICKY_EN
            error_q <= error_q || error_now;
`else
            error_q <= error_now;
`endif
        end
    end

    assign bus.wr_enable    = push_acc;
    assign bus.rd_enable    = pop_acc;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= af_thr_c);
    assign bus.almost_empty = (count_q <= ae_thr_c);
    assign bus.fifo_error   = error_q;
    assign bus.valid_out    = valid_q;
endmodule

// File: tb/tb_fifo_control.sv
// tb/tb_fifo_control.sv - randomized check of fifo_control against a queue-based occupancy model
module tb_fifo_control;
    localparam int depth = 4;

    logic clk;
    logic reset;

    fifo_control_if #(.address_width(2)) bus ();

    fifo_control #(
        .address_width   (2),
        .almost_full_thr (3),
        .almost_empty_thr(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the queue holds the array address each stored entry was written to.
    int q_addr[$];
    int pushes = 0;
    int pops   = 0;
    bit exp_valid = 0;
    bit exp_err   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        pushes    = 0;
        pops      = 0;
        exp_valid = 0;
        exp_err   = 0;
    endtask

    task automatic check_regs();
        int n;
        n = q_addr.size();
        check("count", int'(bus.count), n);
        check("wr_ptr", int'(bus.wr_ptr), pushes % depth);
        check("rd_ptr", int'(bus.rd_ptr), pops % depth);
        check("full", int'(bus.full), int'(n == depth));
        check("empty", int'(bus.empty), int'(n == 0));
        check("almost_full", int'(bus.almost_full), int'(n >= 3));
        check("almost_empty", int'(bus.almost_empty), int'(n <= 1));
        check("valid_out", int'(bus.valid_out), int'(exp_valid));
        check("fifo_error", int'(bus.fifo_error), int'(exp_err));
    endtask

    task automatic cycle(input bit p, input bit r);
        bit emp;
        bit ful;
        bit acc_pop;
        bit acc_push;
        bit err_now;
        @(negedge clk);
        bus.push = p;
        bus.pop  = r;
        #1;
        emp = (q_addr.size() == 0);
        ful = (q_addr.size() == depth);
        check_regs();
        acc_pop  = r && !emp;
        acc_push = p && (!ful || acc_pop);
        check("rd_enable", int'(bus.rd_enable), int'(acc_pop));
        check("wr_enable", int'(bus.wr_enable), int'(acc_push));
        if (acc_pop) begin
            check("read_order", int'(bus.rd_ptr), q_addr[0]);
        end
        @(posedge clk);
        err_now = (p && !acc_push) || (r && emp);
        if (acc_pop) begin
            void'(q_addr.pop_front());
            pops++;
        end
        if (acc_push) begin
            q_addr.push_back(pushes % depth);
            pushes++;
        end
        exp_valid = acc_pop;
`ifdef FIFO_ERR_STICKY_EN
        exp_err = exp_err || err_now;
`else
        exp_err = err_now;
`endif
    endtask

    initial begin
        int bias_push;
        int bias_pop;
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_regs();
        check("rst_wr_enable", int'(bus.wr_enable), 0);
        check("rst_rd_enable", int'(bus.rd_enable), 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill, overflow attempt, full push+pop, drain, underflow.
        repeat (4) cycle(1, 0);
        cycle(1, 0);
        cycle(1, 1);
        repeat (4) cycle(0, 1);
        cycle(0, 1);
        cycle(1, 1);
        cycle(0, 0);

        // Pointer wrap with ordering: push 4, pop 2, push 2, pop 4.
        cycle(0, 1);
        repeat (4) cycle(1, 0);
        repeat (2) cycle(0, 1);
        repeat (2) cycle(1, 0);
        repeat (4) cycle(0, 1);
        cycle(0, 0);

        // Randomized traffic with a drifting push/pop bias to visit full and empty.
        for (int blk = 0; blk < 10; blk++) begin
            bias_push = (blk % 2 == 0) ? 75 : 25;
            bias_pop  = 100 - bias_push;
            for (int i = 0; i < 40; i++) begin
                cycle($urandom_range(0, 99) < bias_push, $urandom_range(0, 99) < bias_pop);
            end
        end

        // Asynchronous reset mid-stream at count 2.
        while (q_addr.size() > 0) cycle(0, 1);
        cycle(1, 0);
        cycle(1, 0);
        cycle(0, 0);
        @(negedge clk);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_regs();
        check("mid_rst_wr_enable", int'(bus.wr_enable), 0);
        check("mid_rst_rd_enable", int'(bus.rd_enable), 0);
        @(negedge clk);
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        cycle(1, 0);
        cycle(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
